// File: rtl/rr_grant_ctrl_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_ctrl_4
// Brief    : Four-requester round-robin arbiter with hold-until-release and a
//            bounded-hold preemption timer. Registered grant index, one-hot
//            grant decode and a one-cycle preemption pulse.
// Revision : 1.0 - initial release
// ============================================================================
module rr_grant_ctrl_4 #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic       gnt_valid,
    output logic [1:0] gnt_idx,
    output logic [3:0] gnt,
    output logic       preempt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    state_t           r_state;
    logic [1:0]       r_ptr;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_gnt_valid;
    logic [1:0]       r_gnt_idx;
    logic [3:0]       r_gnt;
    logic             r_preempt;

    state_t           w_state_nxt;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] w_hold_nxt;
    logic             w_valid_nxt;
    logic [1:0]       w_idx_nxt;
    logic             w_preempt_nxt;

    logic [1:0]       w_win_idx;
    logic             w_win_found;
    logic [1:0]       w_cand;
    logic [3:0]       w_owner_mask;
    logic             w_owner_req;
    logic             w_others;

    // Round-robin scan: ptr+1, ptr+2, ptr+3, then ptr itself last.
    always_comb begin
        w_win_idx   = 2'b00;
        w_win_found = 1'b0;
        w_cand      = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            w_cand = r_ptr + k[1:0];
            if (!w_win_found && req[w_cand]) begin
                w_win_idx   = w_cand;
                w_win_found = 1'b1;
            end
        end
    end

    // Owner's own request and whether anyone else is waiting.
    always_comb begin
        w_owner_mask = 4'b0001 << r_gnt_idx;
        w_owner_req  = req[r_gnt_idx];
        w_others     = |(req & ~w_owner_mask);
    end

    // Next-state and next-output decision for the arbiter.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_valid_nxt   = r_gnt_valid;
        w_idx_nxt     = r_gnt_idx;
        w_preempt_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt = ST_GRANT;
                    w_valid_nxt = 1'b1;
                    w_idx_nxt   = w_win_idx;
                    w_ptr_nxt   = w_win_idx;
                    w_hold_nxt  = c_one;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    if (w_others) begin
                        // Hand over on the same edge so there is no idle bubble.
                        w_idx_nxt  = w_win_idx;
                        w_ptr_nxt  = w_win_idx;
                        w_hold_nxt = c_one;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_hold_nxt  = '0;
                    end
                end else if ((r_hold_cnt >= c_max_hold) && w_others) begin
                    // ptr equals the owner, so the scan reaches it last and
                    // another pending requester always wins here.
                    w_idx_nxt     = w_win_idx;
                    w_ptr_nxt     = w_win_idx;
                    w_hold_nxt    = c_one;
                    w_preempt_nxt = 1'b1;
                end else if (r_hold_cnt < c_max_hold) begin
                    w_hold_nxt = r_hold_cnt + c_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs; ptr resets to 3 so requester 0 is first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'b11;
            r_hold_cnt  <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= 2'b00;
            r_gnt       <= 4'b0000;
            r_preempt   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_gnt_idx   <= w_idx_nxt;
            r_gnt       <= w_valid_nxt ? (4'b0001 << w_idx_nxt) : 4'b0000;
            r_preempt   <= w_preempt_nxt;
        end
    end

    assign gnt_valid = r_gnt_valid;
    assign gnt_idx   = r_gnt_idx;
    assign gnt       = r_gnt;
    assign preempt   = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_ctrl_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_grant_ctrl_4
// Brief    : Self-checking bench for rr_grant_ctrl_4: directed vector table,
//            hand-written reset sequence, randomized traffic vs. a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_grant_ctrl_4;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic [3:0] gnt;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    rr_grant_ctrl_4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt       (gnt),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the resource, for how long, and the pointer.
    bit m_valid;
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_pre;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_owner = 0; m_ptr = 3; m_hold = 0; m_pre = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int  w;
        bit  others;
        w      = pick(r, m_ptr);
        others = (r & ~(4'(1) << m_owner)) != 4'b0000;
        m_pre  = 0;
        if (!m_valid) begin
            if (r != 4'b0000) begin
                m_valid = 1; m_owner = w; m_ptr = w; m_hold = 1;
            end
        end else if (!r[m_owner]) begin
            if (others) begin
                m_owner = w; m_ptr = w; m_hold = 1;
            end else begin
                m_valid = 0;
            end
        end else if (m_hold >= MAX_HOLD && others) begin
            m_owner = w; m_ptr = w; m_hold = 1; m_pre = 1;
        end else begin
            m_hold++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        #1;
        check("reset_valid", 32'(gnt_valid), 32'd0);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_preempt", 32'(preempt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
    endtask

    // Apply one request pattern across one rising edge and advance the model.
    task automatic cycle(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] exp_gnt;
        exp_gnt = m_valid ? (4'(1) << m_owner) : 4'b0000;
        check({tag, "_valid"}, 32'(gnt_valid), 32'(m_valid));
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, "_preempt"}, 32'(preempt), 32'(m_pre));
        if (m_valid) check({tag, "_idx"}, 32'(gnt_idx), 32'(m_owner));
        check({tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       exp_valid;
        logic [3:0] exp_gnt;
        logic       exp_pre;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input bit rs, input logic [3:0] r, input logic v,
                                input logic [3:0] g, input logic p);
        vec_t t;
        t.rst = rs; t.req = r; t.exp_valid = v; t.exp_gnt = g; t.exp_pre = p;
        return t;
    endfunction

    initial begin
        rst_n = 1'b1;
        req   = 4'b0000;
        model_reset();

        // Single request, then release to idle.
        vecs.push_back(mk(1, 4'b0100, 1, 4'b0100, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));
        // All requesting: four cycles each, preempt on every rotation.
        for (int k = 0; k < 17; k++) begin
            vecs.push_back(mk(k == 0, 4'b1111, 1, 4'(1) << ((k / 4) % 4),
                              (k > 0) && (k % 4 == 0)));
        end
        // Back-to-back release from owner 0 to requester 1.
        vecs.push_back(mk(0, 4'b0011, 1, 4'b0001, 0));
        vecs.push_back(mk(0, 4'b0010, 1, 4'b0010, 0));
        // Sole requester 3 keeps the grant, never preempted.
        for (int k = 0; k < 20; k++) vecs.push_back(mk(0, 4'b1000, 1, 4'b1000, 0));
        // Wrap-around 3 -> 0 (long-held owner gets preempted), then back to 3.
        vecs.push_back(mk(0, 4'b1001, 1, 4'b0001, 1));
        vecs.push_back(mk(0, 4'b1000, 1, 4'b1000, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 4'b0000, 0));

        @(negedge clk);
        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            cycle(vecs[i].req);
            check($sformatf("vec%0d_valid", i), 32'(gnt_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("vec%0d_preempt", i), 32'(preempt), 32'(vecs[i].exp_pre));
        end

        // Asynchronous reset mid-grant, then restart from requester 0.
        do_reset();
        cycle(4'b0100);
        check("midrst_pre_gnt", 32'(gnt), 32'h4);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_async_gnt", 32'(gnt), 32'h0);
        check("midrst_async_valid", 32'(gnt_valid), 32'h0);
        model_reset();
        req = 4'b1111;
        @(posedge clk);
        #2 rst_n = 1'b1;
        cycle(4'b1111);
        check("midrst_first_gnt", 32'(gnt), 32'h1);
        check("midrst_first_idx", 32'(gnt_idx), 32'h0);

        // Randomized traffic with sticky requests, occasional reset.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [3:0] r;
            if (n % 150 == 149) do_reset();
            r = req;
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
            cycle(r);
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
